// File: rtl/arbitro_escrita_registradores_if.sv
// Write-port bus between the register-bank arbiter, the datapath (A),
// the long-latency unit (B) and the register bank.
interface arbitro_escrita_registradores_if #(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned LARGURA      = 32
);
    localparam int unsigned OCUP_W = $clog2(PROFUNDIDADE + 1);

    logic               regWriteA;
    logic [4:0]         regEscritaA;
    logic [LARGURA-1:0] DadosEscritaA;
    logic               validB;
    logic               readyB;
    logic [4:0]         regEscritaB;
    logic [LARGURA-1:0] DadosEscritaB;
    logic [4:0]         regLeitura1;
    logic [4:0]         regLeitura2;
    logic               Pendente1;
    logic               Pendente2;
    logic               Parada;
    logic               regWrite;
    logic [4:0]         regEscrita;
    logic [LARGURA-1:0] DadosEscrita;
    logic [OCUP_W-1:0]  Ocupacao;

    modport slave (
        input  regWriteA, regEscritaA, DadosEscritaA,
        input  validB, regEscritaB, DadosEscritaB,
        input  regLeitura1, regLeitura2,
        output readyB, Pendente1, Pendente2, Parada,
        output regWrite, regEscrita, DadosEscrita, Ocupacao
    );

    modport master (
        output regWriteA, regEscritaA, DadosEscritaA,
        output validB, regEscritaB, DadosEscritaB,
        output regLeitura1, regLeitura2,
        input  readyB, Pendente1, Pendente2, Parada,
        input  regWrite, regEscrita, DadosEscrita, Ocupacao
    );
endinterface

// File: rtl/arbitro_escrita_registradores.sv
// Register-bank write-port arbiter: datapath (A) has priority, B results are
// queued in a small FIFO, drained in idle cycles, with a starvation-forced drain.
module arbitro_escrita_registradores #(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned MAX_ESPERA   = 8,
    parameter int unsigned LARGURA      = 32
) (
    input logic                            Clock,
    input logic                            Reset_n,
    arbitro_escrita_registradores_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(PROFUNDIDADE);
    localparam int unsigned OCUP_W = $clog2(PROFUNDIDADE + 1);
    localparam int unsigned ESP_W  = $clog2(MAX_ESPERA + 1);
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ESPERANDO = 2'd1,
        FORCANDO  = 2'd2
    } estado_t;

    estado_t                 r_estado, w_estado_prox;
    logic [PROFUNDIDADE-1:0] r_valido;
    logic [REG_W-1:0]        r_reg   [PROFUNDIDADE];
    logic [LARGURA-1:0]      r_dados [PROFUNDIDADE];
    logic [PTR_W-1:0]        r_ptr_esc, r_ptr_lei;
    logic [OCUP_W-1:0]       r_ocup, w_ocup_prox;
    logic [ESP_W-1:0]        r_espera, w_espera_prox;

    logic               w_a_ativo, w_parada, w_cabeca_valida;
    logic               w_conc_a, w_conc_b, w_ready;
    logic               w_enfileira, w_pop, w_negado, w_mata_push;
    logic               w_pend1, w_pend2;
    logic [REG_W-1:0]   w_reg_banco;
    logic [LARGURA-1:0] w_dados_banco;

    // Grant and FIFO control, all decided from registered state
    assign w_a_ativo       = bus.regWriteA && (bus.regEscritaA != '0);
    assign w_parada        = (r_estado == FORCANDO);
    assign w_cabeca_valida = (r_ocup != '0) && r_valido[r_ptr_lei];
    assign w_conc_a        = !w_parada && w_a_ativo;
    assign w_conc_b        = !w_conc_a && w_cabeca_valida;
    assign w_ready         = (r_ocup != OCUP_W'(PROFUNDIDADE));
    assign w_enfileira     = bus.validB && w_ready && (bus.regEscritaB != '0);
    assign w_pop           = (r_ocup != '0) && (w_conc_b || !r_valido[r_ptr_lei]);
    assign w_negado        = w_cabeca_valida && w_conc_a;
    assign w_mata_push     = w_conc_a && (bus.regEscritaB == bus.regEscritaA);
    assign w_ocup_prox     = r_ocup + OCUP_W'(w_enfileira) - OCUP_W'(w_pop);

    always_comb begin
        w_espera_prox = r_espera;
        if (w_pop) begin
            w_espera_prox = '0;
        end else if (w_negado) begin
            w_espera_prox = r_espera + ESP_W'(1);
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (w_ocup_prox != '0) w_estado_prox = ESPERANDO;
            end
            ESPERANDO: begin
                if (w_ocup_prox == '0) begin
                    w_estado_prox = OCIOSO;
                end else if (w_espera_prox == ESP_W'(MAX_ESPERA)) begin
                    w_estado_prox = FORCANDO;
                end
            end
            FORCANDO: begin
                w_estado_prox = (w_ocup_prox != '0) ? ESPERANDO : OCIOSO;
            end
            default: w_estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_estado <= OCIOSO;
            r_espera <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_espera <= w_espera_prox;
        end
    end

    // Valid bits and pointers; an A write kills any older queued copy of the same register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valido  <= '0;
            r_ptr_esc <= '0;
            r_ptr_lei <= '0;
            r_ocup    <= '0;
        end else begin
            for (int i = 0; i < int'(PROFUNDIDADE); i++) begin
                if (w_conc_a && (r_reg[i] == bus.regEscritaA)) r_valido[i] <= 1'b0;
            end
            if (w_pop) begin
                r_valido[r_ptr_lei] <= 1'b0;
                r_ptr_lei           <= r_ptr_lei + PTR_W'(1);
            end
            if (w_enfileira) begin
                r_valido[r_ptr_esc] <= !w_mata_push;
                r_ptr_esc           <= r_ptr_esc + PTR_W'(1);
            end
            r_ocup <= w_ocup_prox;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_enfileira) begin
            r_reg[r_ptr_esc]   <= bus.regEscritaB;
            r_dados[r_ptr_esc] <= bus.DadosEscritaB;
        end
    end

    always_comb begin
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int i = 0; i < int'(PROFUNDIDADE); i++) begin
            if (r_valido[i] && (r_reg[i] == bus.regLeitura1)) w_pend1 = 1'b1;
            if (r_valido[i] && (r_reg[i] == bus.regLeitura2)) w_pend2 = 1'b1;
        end
        if (bus.regLeitura1 == '0) w_pend1 = 1'b0;
        if (bus.regLeitura2 == '0) w_pend2 = 1'b0;
    end

    always_comb begin
        w_reg_banco   = '0;
        w_dados_banco = '0;
        if (w_conc_a) begin
            w_reg_banco   = bus.regEscritaA;
            w_dados_banco = bus.DadosEscritaA;
        end else if (w_conc_b) begin
            w_reg_banco   = r_reg[r_ptr_lei];
            w_dados_banco = r_dados[r_ptr_lei];
        end
    end

    assign bus.readyB       = w_ready;
    assign bus.Parada       = w_parada;
    assign bus.Pendente1    = w_pend1;
    assign bus.Pendente2    = w_pend2;
    assign bus.regWrite     = w_conc_a || w_conc_b;
    assign bus.regEscrita   = w_reg_banco;
    assign bus.DadosEscrita = w_dados_banco;
    assign bus.Ocupacao     = r_ocup;
endmodule

// File: tb/tb_arbitro_escrita_registradores.sv
// Bench for the register-bank write arbiter: per-cycle vector table plus
// multi-cycle sequences, with a queue of expected B writes at the bank port.
module tb_arbitro_escrita_registradores;
    logic Clock;
    logic Reset_n;

    arbitro_escrita_registradores_if #(.PROFUNDIDADE(4), .LARGURA(32)) bus ();

    arbitro_escrita_registradores #(
        .PROFUNDIDADE(4),
        .MAX_ESPERA  (8),
        .LARGURA     (32)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } esc_t;

    // exp = {readyB, Parada, regWrite, Pendente1, Pendente2, Ocupacao[2:0]}
    typedef struct {
        logic        wa;
        logic [4:0]  ra;
        logic [31:0] da;
        logic        vb;
        logic [4:0]  rb;
        logic [31:0] db;
        logic [4:0]  l1;
        logic [4:0]  l2;
        logic        ga;
        logic        sb;
        logic [7:0]  exp;
    } vec_t;

    esc_t sb_q[$];
    vec_t tab[17];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pushed;
    int   k;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1);
    end

    task automatic verifica(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    task automatic aplica(input logic wa, input logic [4:0] ra, input logic [31:0] da,
                          input logic vb, input logic [4:0] rb, input logic [31:0] db,
                          input logic [4:0] l1, input logic [4:0] l2);
        bus.regWriteA     = wa;
        bus.regEscritaA   = ra;
        bus.DadosEscritaA = da;
        bus.validB        = vb;
        bus.regEscritaB   = rb;
        bus.DadosEscritaB = db;
        bus.regLeitura1   = l1;
        bus.regLeitura2   = l2;
    endtask

    function automatic logic [7:0] estado_saidas();
        return {bus.readyB, bus.Parada, bus.regWrite, bus.Pendente1, bus.Pendente2, bus.Ocupacao};
    endfunction

    // A-granted cycles must show A's write; otherwise any write must be the next queued B result
    task automatic confere_banco(input string nome, input logic a_gr,
                                 input logic [4:0] ra, input logic [31:0] da);
        esc_t e;
        if (a_gr) begin
            verifica({nome, "_A"}, {26'd0, bus.regWrite, bus.regEscrita, bus.DadosEscrita},
                     {26'd0, 1'b1, ra, da});
        end else if (bus.regWrite) begin
            if (sb_q.size() == 0) begin
                verifica({nome, "_inesperada"}, {26'd0, 1'b1, bus.regEscrita, bus.DadosEscrita}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                verifica({nome, "_B"}, {26'd0, 1'b1, bus.regEscrita, bus.DadosEscrita},
                         {26'd0, 1'b1, e.r, e.d});
            end
        end else begin
            verifica({nome, "_ocioso"}, {26'd0, 1'b0, bus.regEscrita, bus.DadosEscrita}, 64'd0);
        end
    endtask

    initial begin
        //           wa    ra     da            vb    rb     db            l1     l2     ga    sb    exp
        tab[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 8'h80};
        tab[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h00001111, 5'd0, 5'd0, 1'b0, 1'b1, 8'h80};
        tab[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 1'b0, 8'hB1};
        tab[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 1'b0, 8'h80};
        tab[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h0000DEAD, 5'd0, 5'd0, 1'b0, 1'b0, 8'h80};
        tab[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 8'h80};
        tab[6]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'hAA,       5'd9, 5'd3, 1'b1, 1'b0, 8'hA0};
        tab[7]  = '{1'b1, 5'd9, 32'hBB,       1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 1'b1, 1'b0, 8'hB1};
        tab[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 1'b0, 1'b0, 8'h81};
        tab[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 1'b0, 1'b0, 8'h80};
        tab[10] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd4, 32'h45,       5'd4, 5'd0, 1'b1, 1'b0, 8'hA0};
        tab[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd4, 5'd0, 1'b0, 1'b0, 8'h81};
        tab[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd4, 5'd0, 1'b0, 1'b0, 8'h80};
        tab[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h66,       5'd0, 5'd6, 1'b0, 1'b1, 8'h80};
        tab[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd6, 1'b0, 1'b0, 8'hA9};
        tab[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd6, 1'b0, 1'b0, 8'h80};
        tab[16] = '{1'b1, 5'd0, 32'h99,       1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 8'h80};

        // Reset state, observed while reset is held
        aplica(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #2;
        verifica("reset_saidas", 64'(estado_saidas()), 64'h80);
        confere_banco("reset", 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Single-cycle vectors
        for (int n = 0; n < 17; n++) begin
            @(posedge Clock);
            #1;
            aplica(tab[n].wa, tab[n].ra, tab[n].da, tab[n].vb, tab[n].rb, tab[n].db, tab[n].l1, tab[n].l2);
            if (tab[n].sb) sb_q.push_back('{tab[n].rb, tab[n].db});
            @(negedge Clock);
            verifica($sformatf("vetor%0d_saidas", n), 64'(estado_saidas()), 64'(tab[n].exp));
            confere_banco($sformatf("vetor%0d", n), tab[n].ga, tab[n].ra, tab[n].da);
        end

        // Starvation: A writes r3 every cycle, forced drain of r7 on the 9th cycle after the push
        for (int i = 0; i <= 10; i++) begin
            k = (i < 10) ? i : 9;
            @(posedge Clock);
            #1;
            aplica(1'b1, 5'd3, 32'h300 + k, i == 0, 5'd7, 32'h77, 5'd0, 5'd0);
            @(negedge Clock);
            verifica($sformatf("t2_parada_c%0d", i), 64'(bus.Parada), 64'(i == 9));
            confere_banco($sformatf("t2_c%0d", i), i != 9, 5'd3, 32'h300 + k);
            if (i == 0 && bus.readyB) sb_q.push_back('{5'd7, 32'h77});
        end
        @(posedge Clock);
        #1;
        aplica(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge Clock);
        verifica("t2_final", 64'(estado_saidas()), 64'h80);
        verifica("t2_fila", 64'(sb_q.size()), 64'd0);

        // Full FIFO: five B results while A is busy, drained in order once A idles
        pushed = 0;
        for (int c = 0; c < 40; c++) begin
            if (pushed == 5 && sb_q.size() == 0 && c > 6) break;
            @(posedge Clock);
            #1;
            aplica(c < 6, 5'd1, 32'h100 + c, pushed < 5, 5'(10 + pushed), 32'hB00 + pushed, 5'd0, 5'd0);
            @(negedge Clock);
            if (c == 4) verifica("t4_cheio", 64'({bus.readyB, bus.Ocupacao}), 64'({1'b0, 3'd4}));
            confere_banco($sformatf("t4_c%0d", c), c < 6, 5'd1, 32'h100 + c);
            if (bus.validB && bus.readyB) begin
                sb_q.push_back('{5'(10 + pushed), 32'hB00 + pushed});
                pushed++;
            end
        end
        verifica("t4_enviados", 64'(pushed), 64'd5);
        verifica("t4_fila", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset with three queued entries
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock);
            #1;
            aplica(1'b1, 5'd1, 32'h200 + c, 1'b1, 5'(20 + c), 32'hC00 + c, 5'd20, 5'd22);
            @(negedge Clock);
            confere_banco($sformatf("t6_c%0d", c), 1'b1, 5'd1, 32'h200 + c);
        end
        @(posedge Clock);
        #1;
        aplica(1'b1, 5'd1, 32'h203, 1'b0, 5'd0, 32'h0, 5'd20, 5'd22);
        @(negedge Clock);
        verifica("t6_antes", 64'({bus.Ocupacao, bus.Pendente1, bus.Pendente2}), 64'({3'd3, 1'b1, 1'b1}));
        aplica(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd22);
        #1 Reset_n = 1'b0;
        #1;
        verifica("t6_reset", 64'(estado_saidas()), 64'h80);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        verifica("t6_pos_reset", 64'(estado_saidas()), 64'h80);
        confere_banco("t6_pos", 1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
